// File: rtl/hci_hwpe_port_arbiter.sv
// Round-robin arbiter sharing one wide HWPE port between NB_REQ requesters, with an in-order ID FIFO
// for response routing. Define HCI_ARB_STALL_CNT_EN to build the per-requester stall counters.
module hci_hwpe_port_arbiter #(
    parameter int NB_REQ          = 2,
    parameter int DW              = 64,
    parameter int AW              = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic [NB_REQ-1:0]        in_req_i,
    output logic [NB_REQ-1:0]        in_gnt_o,
    input  logic [NB_REQ-1:0]        in_wen_i,
    input  logic [NB_REQ*AW-1:0]     in_add_i,
    input  logic [NB_REQ*DW/8-1:0]   in_be_i,
    input  logic [NB_REQ*DW-1:0]     in_data_i,
    output logic [NB_REQ-1:0]        in_r_valid_o,
    output logic [DW-1:0]            in_r_data_o,
    output logic                     out_req_o,
    output logic                     out_wen_o,
    output logic [AW-1:0]            out_add_o,
    output logic [DW/8-1:0]          out_be_o,
    output logic [DW-1:0]            out_data_o,
    input  logic                     out_gnt_i,
    input  logic                     out_r_valid_i,
    input  logic [DW-1:0]            out_r_data_i,
    output logic                     err_o,
    output logic [NB_REQ*32-1:0]     stall_cnt_o
);

    localparam int PW = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
    localparam int FW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int BW = DW / 8;

    logic [PW-1:0] prio_q, prio_d;
    logic [PW-1:0] id_fifo_q [MAX_OUTSTANDING];
    logic [PW-1:0] id_fifo_d [MAX_OUTSTANDING];
    logic [FW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] occ_q, occ_d;
    logic          err_q, err_d;

    logic          win_valid;
    logic [PW-1:0] win_idx;
    logic [PW-1:0] head_id;
    logic          full;
    logic          empty;
    logic          handshake;
    logic          pop;

    function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NB_REQ) begin
            sum = sum - NB_REQ;
        end
        return PW'(sum);
    endfunction

    // First requesting index at or above prio, wrapping around
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NB_REQ; i++) begin
            if (!win_valid && in_req_i[rr_index(prio_q, i)]) begin
                win_valid = 1'b1;
                win_idx   = rr_index(prio_q, i);
            end
        end
    end

    assign full      = (occ_q == CW'(MAX_OUTSTANDING));
    assign empty     = (occ_q == '0);
    assign out_req_o = (|in_req_i) & ~full;
    assign handshake = out_req_o & out_gnt_i;
    assign pop       = out_r_valid_i & ~empty;
    assign head_id   = id_fifo_q[rd_ptr_q];

    always_comb begin
        out_wen_o  = 1'b0;
        out_add_o  = '0;
        out_be_o   = '0;
        out_data_o = '0;
        in_gnt_o   = '0;
        if (win_valid) begin
            out_wen_o          = in_wen_i[win_idx];
            out_add_o          = in_add_i[int'(win_idx)*AW +: AW];
            out_be_o           = in_be_i[int'(win_idx)*BW +: BW];
            out_data_o         = in_data_i[int'(win_idx)*DW +: DW];
            in_gnt_o[win_idx]  = handshake;
        end
    end

    always_comb begin
        in_r_valid_o = '0;
        if (pop) begin
            in_r_valid_o[head_id] = 1'b1;
        end
    end

    assign in_r_data_o = out_r_data_i;
    assign err_o       = err_q;

    always_comb begin
        prio_d    = prio_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;
        err_d     = err_q;
        id_fifo_d = id_fifo_q;

        if (handshake) begin
            id_fifo_d[wr_ptr_q] = win_idx;
            wr_ptr_d = (wr_ptr_q == FW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + FW'(1);
            prio_d   = (win_idx == PW'(NB_REQ - 1)) ? '0 : win_idx + PW'(1);
        end

        if (pop) begin
            rd_ptr_d = (rd_ptr_q == FW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + FW'(1);
        end

        // A response with nothing outstanding has no owner
        if (out_r_valid_i && empty) begin
            err_d = 1'b1;
        end

        case ({handshake, pop})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            prio_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                id_fifo_q[i] <= '0;
            end
        end else begin
            prio_q    <= prio_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            err_q     <= err_d;
            id_fifo_q <= id_fifo_d;
        end
    end

`ifdef HCI_ARB_STALL_CNT_EN
    logic [31:0] stall_cnt_q [NB_REQ];
    logic [31:0] stall_cnt_d [NB_REQ];

    // Saturating count of cycles a requester waited without a grant
    always_comb begin
        for (int r = 0; r < NB_REQ; r++) begin
            stall_cnt_d[r] = stall_cnt_q[r];
            if (in_req_i[r] && !in_gnt_o[r] && (stall_cnt_q[r] != 32'hFFFF_FFFF)) begin
                stall_cnt_d[r] = stall_cnt_q[r] + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            for (int r = 0; r < NB_REQ; r++) begin
                stall_cnt_q[r] <= '0;
            end
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        stall_cnt_o = '0;
        for (int r = 0; r < NB_REQ; r++) begin
            stall_cnt_o[r*32 +: 32] = stall_cnt_q[r];
        end
    end
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hci_hwpe_port_arbiter.sv
// Directed self-checking bench for hci_hwpe_port_arbiter (NB_REQ=2, DW=64, AW=32, MAX_OUTSTANDING=2).
module tb_hci_hwpe_port_arbiter;

    localparam int NB_REQ = 2;
    localparam int DW     = 64;
    localparam int AW     = 32;
    localparam int MAXO   = 2;

    logic                    clk;
    logic                    rstN;
    logic                    clear;
    logic [NB_REQ-1:0]       inReq;
    logic [NB_REQ-1:0]       inGnt;
    logic [NB_REQ-1:0]       inWen;
    logic [NB_REQ*AW-1:0]    inAdd;
    logic [NB_REQ*DW/8-1:0]  inBe;
    logic [NB_REQ*DW-1:0]    inData;
    logic [NB_REQ-1:0]       inRValid;
    logic [DW-1:0]           inRData;
    logic                    outReq;
    logic                    outWen;
    logic [AW-1:0]           outAdd;
    logic [DW/8-1:0]         outBe;
    logic [DW-1:0]           outData;
    logic                    outGnt;
    logic                    outRValid;
    logic [DW-1:0]           outRData;
    logic                    err;
    logic [NB_REQ*32-1:0]    stallCnt;

    int errors = 0;
    int checks = 0;

    hci_hwpe_port_arbiter #(
        .NB_REQ(NB_REQ), .DW(DW), .AW(AW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_i(clk), .rst_ni(rstN), .clear_i(clear),
        .in_req_i(inReq), .in_gnt_o(inGnt), .in_wen_i(inWen),
        .in_add_i(inAdd), .in_be_i(inBe), .in_data_i(inData),
        .in_r_valid_o(inRValid), .in_r_data_o(inRData),
        .out_req_o(outReq), .out_wen_o(outWen), .out_add_o(outAdd),
        .out_be_o(outBe), .out_data_o(outData),
        .out_gnt_i(outGnt), .out_r_valid_i(outRValid), .out_r_data_i(outRData),
        .err_o(err), .stall_cnt_o(stallCnt)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one cycle's inputs shortly after the edge and lets the combinational paths settle
    task automatic applyStimulus(input logic [1:0] req, input logic gnt, input logic rv,
                                 input logic clr, input logic [63:0] rdata);
        inReq     = req;
        outGnt    = gnt;
        outRValid = rv;
        clear     = clr;
        outRData  = rdata;
        #2;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    logic [1:0]  t1Gnt [4];
    logic [1:0]  t1Rv  [4];
    logic [31:0] t1Add [4];

    initial begin
        t1Gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
        t1Rv  = '{2'b00, 2'b01, 2'b10, 2'b01};
        t1Add = '{32'h0000_1000, 32'h0000_2000, 32'h0000_1000, 32'h0000_2000};

        inAdd     = {32'h0000_2000, 32'h0000_1000};
        inData    = {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        inBe      = {8'hF0, 8'h0F};
        inWen     = 2'b01;
        inReq     = '0;
        outGnt    = 1'b0;
        outRValid = 1'b0;
        outRData  = '0;
        clear     = 1'b0;
        rstN      = 1'b0;
        nextCycle();
        rstN = 1'b1;

        // Reset state
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 64'h0);
        checkOutput("rst_out_req", {63'd0, outReq}, 64'd0);
        checkOutput("rst_gnt", {62'd0, inGnt}, 64'd0);
        checkOutput("rst_rvalid", {62'd0, inRValid}, 64'd0);
        checkOutput("rst_err", {63'd0, err}, 64'd0);
        checkOutput("rst_stall", stallCnt, 64'd0);
        checkOutput("rst_add", {32'd0, outAdd}, 64'd0);
        nextCycle();

        // Both requesters, responses one cycle after each grant
        for (int k = 0; k < 4; k++) begin
            applyStimulus(2'b11, 1'b1, (k > 0), 1'b0, 64'hCAFE_0000_0000_0000 + 64'(k));
            checkOutput($sformatf("alt_gnt%0d", k), {62'd0, inGnt}, {62'd0, t1Gnt[k]});
            checkOutput($sformatf("alt_rv%0d", k), {62'd0, inRValid}, {62'd0, t1Rv[k]});
            checkOutput($sformatf("alt_add%0d", k), {32'd0, outAdd}, {32'd0, t1Add[k]});
            checkOutput($sformatf("alt_rdata%0d", k), inRData, 64'hCAFE_0000_0000_0000 + 64'(k));
            nextCycle();
        end
        applyStimulus(2'b00, 1'b0, 1'b1, 1'b0, 64'h1234);
        checkOutput("alt_last_rv", {62'd0, inRValid}, 64'b10);
        checkOutput("alt_idle_req", {63'd0, outReq}, 64'd0);
        checkOutput("alt_idle_data", outData, 64'd0);
        nextCycle();

        // Requester 1 alone for four cycles, then both
        applyStimulus(2'b10, 1'b1, 1'b0, 1'b0, 64'h0);
        checkOutput("solo_gnt0", {62'd0, inGnt}, 64'b10);
        checkOutput("solo_be0", {56'd0, outBe}, 64'hF0);
        checkOutput("solo_wen0", {63'd0, outWen}, 64'd0);
        nextCycle();
        for (int k = 1; k < 4; k++) begin
            applyStimulus(2'b10, 1'b1, 1'b1, 1'b0, 64'h0);
            checkOutput($sformatf("solo_gnt%0d", k), {62'd0, inGnt}, 64'b10);
            checkOutput($sformatf("solo_rv%0d", k), {62'd0, inRValid}, 64'b10);
            nextCycle();
        end
        applyStimulus(2'b11, 1'b1, 1'b1, 1'b0, 64'h0);
        checkOutput("solo_both_gnt", {62'd0, inGnt}, 64'b01);
        checkOutput("solo_both_rv", {62'd0, inRValid}, 64'b10);
        checkOutput("solo_both_wen", {63'd0, outWen}, 64'd1);
        nextCycle();
        applyStimulus(2'b00, 1'b0, 1'b1, 1'b0, 64'h0);
        checkOutput("solo_drain_rv", {62'd0, inRValid}, 64'b01);
        nextCycle();

        // Fill the ID FIFO with responses withheld
        applyStimulus(2'b01, 1'b1, 1'b0, 1'b0, 64'h0);
        checkOutput("full_gnt0", {62'd0, inGnt}, 64'b01);
        nextCycle();
        applyStimulus(2'b01, 1'b1, 1'b0, 1'b0, 64'h0);
        checkOutput("full_gnt1", {62'd0, inGnt}, 64'b01);
        nextCycle();
        applyStimulus(2'b01, 1'b1, 1'b0, 1'b0, 64'h0);
        checkOutput("full_req", {63'd0, outReq}, 64'd0);
        checkOutput("full_gnt2", {62'd0, inGnt}, 64'd0);
        nextCycle();
        applyStimulus(2'b01, 1'b1, 1'b1, 1'b0, 64'h0);
        checkOutput("full_pop_req", {63'd0, outReq}, 64'd0);
        checkOutput("full_pop_rv", {62'd0, inRValid}, 64'b01);
        nextCycle();
        applyStimulus(2'b01, 1'b0, 1'b0, 1'b0, 64'h0);
        checkOutput("full_after_req", {63'd0, outReq}, 64'd1);
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b1, 64'h0);
        nextCycle();

        // Shared port stalls five cycles with requester 0 pending
        for (int k = 0; k < 5; k++) begin
            applyStimulus(2'b01, 1'b0, 1'b0, 1'b0, 64'h0);
            checkOutput($sformatf("stall_req%0d", k), {63'd0, outReq}, 64'd1);
            checkOutput($sformatf("stall_gnt%0d", k), {62'd0, inGnt}, 64'd0);
            nextCycle();
        end
        applyStimulus(2'b01, 1'b1, 1'b0, 1'b0, 64'h0);
        checkOutput("stall_add", {32'd0, outAdd}, 64'h1000);
        checkOutput("stall_release_gnt", {62'd0, inGnt}, 64'b01);
`ifdef HCI_ARB_STALL_CNT_EN
        checkOutput("stall_cnt0", {32'd0, stallCnt[31:0]}, 64'd5);
`else
        checkOutput("stall_cnt0", {32'd0, stallCnt[31:0]}, 64'd0);
`endif
        checkOutput("stall_cnt1", {32'd0, stallCnt[63:32]}, 64'd0);
        nextCycle();
        applyStimulus(2'b00, 1'b0, 1'b1, 1'b0, 64'h0);
        checkOutput("stall_drain_rv", {62'd0, inRValid}, 64'b01);
        nextCycle();

        // Response with nothing outstanding
        applyStimulus(2'b00, 1'b0, 1'b1, 1'b0, 64'h0);
        checkOutput("orphan_rv", {62'd0, inRValid}, 64'd0);
        checkOutput("orphan_err_before", {63'd0, err}, 64'd0);
        nextCycle();
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 64'h0);
        checkOutput("orphan_err_set", {63'd0, err}, 64'd1);
        nextCycle();
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b1, 64'h0);
        checkOutput("orphan_err_held", {63'd0, err}, 64'd1);
        nextCycle();
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 64'h0);
        checkOutput("orphan_err_clear", {63'd0, err}, 64'd0);
        nextCycle();

        // Reset with two entries outstanding
        applyStimulus(2'b01, 1'b1, 1'b0, 1'b0, 64'h0);
        checkOutput("rstmid_gnt0", {62'd0, inGnt}, 64'b01);
        nextCycle();
        applyStimulus(2'b01, 1'b1, 1'b0, 1'b0, 64'h0);
        checkOutput("rstmid_gnt1", {62'd0, inGnt}, 64'b01);
        nextCycle();
        applyStimulus(2'b01, 1'b1, 1'b0, 1'b0, 64'h0);
        checkOutput("rstmid_full", {63'd0, outReq}, 64'd0);
        rstN = 1'b0;
        nextCycle();
        rstN = 1'b1;
        applyStimulus(2'b01, 1'b0, 1'b0, 1'b0, 64'h0);
        checkOutput("rstmid_req", {63'd0, outReq}, 64'd1);
        nextCycle();
        applyStimulus(2'b00, 1'b0, 1'b1, 1'b0, 64'h0);
        checkOutput("rstmid_rv", {62'd0, inRValid}, 64'd0);
        nextCycle();
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 64'h0);
        checkOutput("rstmid_err", {63'd0, err}, 64'd1);
        nextCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
